load_store_unit: RTL and testbench



---
 rtl/load_store_unit_pkg.sv | 39 +++
 rtl/lsu_byte_lane.sv | 61 ++++++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings and types for the load/store unit: access sizes, FSM states,
// the latched request payload and the alignment helper.
package load_store_unit_pkg;

  localparam int unsigned LSU_SRAM_BYTES = 1024;
  localparam int unsigned LSU_DATA_W     = 32;
  localparam int unsigned LSU_STATE_W    = 3;

  localparam logic [1:0] LSU_SIZE_BYTE = 2'b00;
  localparam logic [1:0] LSU_SIZE_HALF = 2'b01;
  localparam logic [1:0] LSU_SIZE_WORD = 2'b10;
  localparam logic [1:0] LSU_SIZE_RSVD = 2'b11;

  localparam logic [LSU_STATE_W-1:0] LSU_IDLE  = 3'd0;
  localparam logic [LSU_STATE_W-1:0] LSU_LOAD  = 3'd1;
  localparam logic [LSU_STATE_W-1:0] LSU_RMW   = 3'd2;
  localparam logic [LSU_STATE_W-1:0] LSU_WRITE = 3'd3;
  localparam logic [LSU_STATE_W-1:0] LSU_RESP  = 3'd4;

  // Request fields kept after accept; direction is carried by the FSM state.
  typedef struct packed {
    logic [1:0]            size;
    logic                  is_signed;
    logic [1:0]            lane;
    logic [LSU_DATA_W-1:0] wdata;
  } lsu_req_t;

  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (size)
      LSU_SIZE_HALF: bad = lo[0];
      LSU_SIZE_WORD: bad = (lo != 2'b00);
      default:       bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane steering: extracts a sub-word from a memory word for loads
// and merges store data into a memory word for read-modify-write.
module lsu_byte_lane
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] data_i,
  output logic [31:0] extract_c,
  output logic [31:0] merge_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  shamt;
  logic [31:0] mask;
  logic [31:0] ins;

  // Little-endian lane selection; halfword lanes are 0 or 2 once aligned.
  always_comb begin
    byte_sel = 8'h00;
    case (lane_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

    extract_c = word_i;
    case (size_i)
      LSU_SIZE_BYTE: extract_c = signed_i ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      LSU_SIZE_HALF: extract_c = signed_i ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
      default:       extract_c = word_i;
    endcase
  end

  always_comb begin
    shamt = {lane_i, 3'b000};
    mask  = 32'hFFFF_FFFF;
    ins   = data_i;
    case (size_i)
      LSU_SIZE_BYTE: begin
        mask = 32'h0000_00FF << shamt;
        ins  = {24'h0, data_i[7:0]} << shamt;
      end
      LSU_SIZE_HALF: begin
        mask = 32'h0000_FFFF << shamt;
        ins  = {16'h0, data_i[15:0]} << shamt;
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        ins  = data_i;
      end
    endcase
    merge_c = (word_i & ~mask) | (ins & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word core requests into word-aligned SRAM
// accesses, with read-modify-write for sub-word stores and access faulting.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned SRAM_BYTES = LSU_SRAM_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] LAST_WORD = 32'(SRAM_BYTES - 4);

  logic [LSU_STATE_W-1:0] state_q, state_d;
  lsu_req_t               req_q, req_d;
  logic [31:0]            mem_addr_q, mem_addr_d;
  logic                   mem_we_q, mem_we_d;
  logic [31:0]            mem_wdata_q, mem_wdata_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [31:0]            resp_rdata_q, resp_rdata_d;
  logic                   resp_fault_q, resp_fault_d;

  logic                   accept_c;
  logic                   fault_c;
  logic [31:0]            word_addr_c;
  logic [31:0]            extract_c;
  logic [31:0]            merge_c;

  assign req_ready   = (state_q == LSU_IDLE);
  assign accept_c    = req_valid && req_ready;
  assign word_addr_c = {req_addr[31:2], 2'b00};
  assign fault_c     = (req_size == LSU_SIZE_RSVD)
                    || lsu_misaligned(req_size, req_addr[1:0])
                    || (word_addr_c > LAST_WORD);

  lsu_byte_lane u_lane (
    .word_i   (mem_rdata),
    .lane_i   (req_q.lane),
    .size_i   (req_q.size),
    .signed_i (req_q.is_signed),
    .data_i   (req_q.wdata),
    .extract_c(extract_c),
    .merge_c  (merge_c)
  );

  // Next-state and registered-output decode; response fields clear by default.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_fault_d = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        if (accept_c) begin
          req_d.size      = req_size;
          req_d.is_signed = req_signed;
          req_d.lane      = req_addr[1:0];
          req_d.wdata     = req_wdata;
          if (fault_c) begin
            state_d      = LSU_RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else begin
            mem_addr_d = word_addr_c;
            if (!req_we) begin
              state_d = LSU_LOAD;
            end else if (req_size == LSU_SIZE_WORD) begin
              state_d     = LSU_WRITE;
              mem_we_d    = 1'b1;
              mem_wdata_d = req_wdata;
            end else begin
              state_d = LSU_RMW;
            end
          end
        end
      end
      LSU_LOAD: begin
        resp_rdata_d = extract_c;
        resp_valid_d = 1'b1;
        state_d      = LSU_RESP;
      end
      LSU_RMW: begin
        mem_wdata_d = merge_c;
        mem_we_d    = 1'b1;
        state_d     = LSU_WRITE;
      end
      LSU_WRITE: begin
        resp_valid_d = 1'b1;
        state_d      = LSU_RESP;
      end
      LSU_RESP: begin
        state_d = LSU_IDLE;
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LSU_IDLE;
      req_q        <= '0;
      mem_addr_q   <= 32'h0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-wide SRAM model on the memory port.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] sram [256];

  load_store_unit #(.SRAM_BYTES(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_signed(req_signed),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_fault(resp_fault),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = sram[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) sram[mem_addr[9:2]] <= mem_wdata;

  // Issue one request and observe it until resp_valid (lat stays -1 on timeout).
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic fault,
                        output int we_cnt, output logic [31:0] w_addr,
                        output logic [31:0] w_data, output logic [31:0] r_maddr);
    lat = -1; rdata = 32'h0; fault = 1'b0; we_cnt = 0;
    w_addr = 32'h0; w_data = 32'h0; r_maddr = 32'h0;
    @(negedge clk);
    req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_we) begin
        we_cnt++; w_addr = mem_addr; w_data = mem_wdata;
      end
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; fault = resp_fault; r_maddr = mem_addr;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    #12;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if (resp_valid !== 1'b0 || resp_fault !== 1'b0 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_resp: got v=%b f=%b d=%h expected 0 0 00000000", resp_valid, resp_fault, resp_rdata);
    end
    checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_mem: got we=%b a=%h d=%h expected 0 0 0", mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_word();
    int lat, wc; logic [31:0] rd, wa, wd, ma; logic f;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, f, wc, wa, wd, ma);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d expected 2", lat); end
    checks++; if (wc !== 1 || wa !== 32'h10 || wd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_write: got cnt=%0d a=%h d=%h expected 1 00000010 deadbeef", wc, wa, wd);
    end
    checks++; if (f !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sw_resp: got f=%b d=%h expected 0 0", f, rd); end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, f, wc, wa, wd, ma);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d expected 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF || f !== 1'b0 || wc !== 0) begin
      errors++; $display("FAIL lw_data: got d=%h f=%b we=%0d expected deadbeef 0 0", rd, f, wc);
    end
  endtask

  task automatic test_byte();
    int lat, wc; logic [31:0] rd, wa, wd, ma; logic f;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h88776655, lat, rd, f, wc, wa, wd, ma);
    do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000A5, lat, rd, f, wc, wa, wd, ma);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency: got %0d expected 3", lat); end
    checks++; if (wc !== 1 || wa !== 32'h10 || wd !== 32'h88A56655) begin
      errors++; $display("FAIL sb_merge: got cnt=%0d a=%h d=%h expected 1 00000010 88a56655", wc, wa, wd);
    end
    do_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, lat, rd, f, wc, wa, wd, ma);
    checks++; if (rd !== 32'h000000A5 || lat !== 2) begin
      errors++; $display("FAIL lbu: got d=%h lat=%0d expected 000000a5 2", rd, lat);
    end
    do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, lat, rd, f, wc, wa, wd, ma);
    checks++; if (rd !== 32'hFFFFFFA5) begin errors++; $display("FAIL lb: got %h expected ffffffa5", rd); end
  endtask

  task automatic test_half();
    int lat, wc; logic [31:0] rd, wa, wd, ma; logic f;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h88776655, lat, rd, f, wc, wa, wd, ma);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rd, f, wc, wa, wd, ma);
    checks++; if (rd !== 32'hFFFF8877) begin errors++; $display("FAIL lh: got %h expected ffff8877", rd); end
    do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, rd, f, wc, wa, wd, ma);
    checks++; if (rd !== 32'h00006655) begin errors++; $display("FAIL lhu: got %h expected 00006655", rd); end
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, lat, rd, f, wc, wa, wd, ma);
    checks++; if (lat !== 3 || wc !== 1 || wd !== 32'h12346655) begin
      errors++; $display("FAIL sh_merge: got lat=%0d cnt=%0d d=%h expected 3 1 12346655", lat, wc, wd);
    end
  endtask

  task automatic test_fault();
    int lat, wc; logic [31:0] rd, wa, wd, ma; logic f;
    logic        t_we   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  t_size [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10};
    logic [31:0] t_addr [5] = '{32'h11, 32'h13, 32'h10, 32'd1024, 32'h41};
    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, lat, rd, f, wc, wa, wd, ma);
    for (int i = 0; i < 5; i++) begin
      do_req(t_we[i], t_size[i], 1'b0, t_addr[i], 32'h5555AAAA, lat, rd, f, wc, wa, wd, ma);
      checks++; if (lat !== 1 || f !== 1'b1 || rd !== 32'h0) begin
        errors++; $display("FAIL fault_%0d: got lat=%0d f=%b d=%h expected 1 1 0", i, lat, f, rd);
      end
      checks++; if (wc !== 0 || ma !== 32'h40) begin
        errors++; $display("FAIL fault_mem_%0d: got we=%0d a=%h expected 0 00000040", i, wc, ma);
      end
    end
    do_req(1'b1, 2'b10, 1'b0, 32'd1020, 32'h0BADF00D, lat, rd, f, wc, wa, wd, ma);
    do_req(1'b0, 2'b10, 1'b0, 32'd1020, 32'h0, lat, rd, f, wc, wa, wd, ma);
    checks++; if (f !== 1'b0 || lat !== 2 || rd !== 32'h0BADF00D) begin
      errors++; $display("FAIL last_word: got f=%b lat=%0d d=%h expected 0 2 0badf00d", f, lat, rd);
    end
  endtask

  task automatic test_reset_mid();
    int lat, wc, vc; logic [31:0] rd, wa, wd, ma; logic f;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h12; req_wdata = 32'h00000077; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_async: got we=%b v=%b rdy=%b expected 0 0 1", mem_we, resp_valid, req_ready);
    end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    wc = 0; vc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_we) wc++;
      if (resp_valid) vc++;
    end
    checks++; if (wc !== 0 || vc !== 0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_quiet: got we=%0d v=%0d rdy=%b expected 0 0 1", wc, vc, req_ready);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, f, wc, wa, wd, ma);
    checks++; if (rd !== 32'h12346655) begin errors++; $display("FAIL rst_mid_mem: got %h expected 12346655", rd); end
  endtask

  task automatic test_back_to_back();
    int lat, wc, idx, got, cyc; logic [31:0] rd, wa, wd, ma; logic f, take;
    logic [31:0] addrs [3] = '{32'h20, 32'h24, 32'h28};
    logic [31:0] exp_d [3] = '{32'h11112222, 32'h33334444, 32'h55556666};
    logic [31:0] got_d [3];
    int          acc   [3];
    for (int i = 0; i < 3; i++)
      do_req(1'b1, 2'b10, 1'b0, addrs[i], exp_d[i], lat, rd, f, wc, wa, wd, ma);
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = addrs[0]; req_valid = 1'b1;
    idx = 0; got = 0; cyc = 0;
    while ((idx < 3 || got < 3) && cyc < 40) begin
      if (resp_valid && got < 3) begin got_d[got] = resp_rdata; got++; end
      take = req_valid && req_ready;
      if (take) begin acc[idx] = cyc; idx++; end
      @(posedge clk); #1;
      cyc++;
      if (take) begin
        if (idx < 3) req_addr = addrs[idx];
        else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    checks++; if (idx !== 3 || got !== 3) begin
      errors++; $display("FAIL b2b_count: got acc=%0d resp=%0d expected 3 3", idx, got);
    end else begin
      checks++; if (acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3) begin
        errors++; $display("FAIL b2b_spacing: got %0d %0d expected 3 3", acc[1] - acc[0], acc[2] - acc[1]);
      end
      for (int i = 0; i < 3; i++) begin
        checks++; if (got_d[i] !== exp_d[i]) begin
          errors++; $display("FAIL b2b_data_%0d: got %h expected %h", i, got_d[i], exp_d[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_fault();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
